// File: rtl/restore_mul_seq.sv
// Sequential shift-add reconstructor: dividend = quotient * divisor + remainder, one bit per clock.
// Optional range flag (remainder >= divisor) is built when RESTORE_MUL_RANGE_CHECK_EN is defined.
module restore_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [2*WIDTH-1:0] dividend,
  output logic               dout_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 din_ready_q;
  logic                 dout_valid_q;
  logic [2*WIDTH-1:0]   dividend_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 last_step;

  // The last step's add is folded straight into the output register.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign last_step = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dividend_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            acc_q       <= {{WIDTH{1'b0}}, remainder};
            mcand_q     <= {{WIDTH{1'b0}}, divisor};
            mplier_q    <= quotient;
            cnt_q       <= '0;
            din_ready_q <= 1'b0;
            state_q     <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) begin
            dividend_q   <= acc_d;
            dout_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dividend   = dividend_q;

`ifdef RESTORE_MUL_RANGE_CHECK_EN
  logic err_q;
  logic dout_err_q;

  // Flag is captured at accept and only exposed while the result is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      dout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (din_valid) err_q <= (remainder >= divisor);
        CALC:    if (last_step) dout_err_q <= err_q;
        DONE:    if (dout_ready) dout_err_q <= 1'b0;
        default: dout_err_q <= 1'b0;
      endcase
    end
  end

  assign dout_err = dout_err_q;
`else
  assign dout_err = 1'b0;
`endif

endmodule
